rshp_bfifo: RTL and testbench
=============================

RSHP_BFIFO -- requirements
Module: rshp_bfifo

Interface
REQ-001 The block SHALL have a parameter DW, default 512, giving the data bus width in bits; DW/8 is the number of bus bytes (NB).
REQ-002 The block SHALL have a parameter DEPTH_B, default 192, giving the buffer depth in bytes; DEPTH_B >= NB is legal and DEPTH_B need not be a power of two.
REQ-003 Derived widths SHALL be: BW = $clog2(NB)+1 for byte counts, CW = $clog2(DEPTH_B)+1 for fill counts, PW = $clog2(DEPTH_B) for pointers.
REQ-004 The block SHALL run from one clock and one reset: clk is the clock; reset_n is the reset, asynchronous and active-low.
REQ-005 Ports, in order:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- init_pulse  in  1  synchronous clear of all state
- wvalid  in  1  write request
- wbyte  in  BW  number of valid low bytes in wdata (0..NB)
- wdata  in  DW  write data; byte 0 is the oldest byte
- wready  out  1  space for a full bus word is available
- rreq  in  1  read request
- rbyte  in  BW  number of bytes to read (0..NB)
- rpeek  in  1  read without consuming
- rdata  out  DW  read data
- rvld  out  1  rdata is valid
- vbyte  out  CW  bytes currently stored
- fbyte  out  CW  free bytes (DEPTH_B - vbyte)
- ovf_err  out  1  sticky overflow flag
- udf_err  out  1  sticky underflow flag

Function
REQ-006 wready SHALL be combinational from registered state: wready = (fbyte >= NB).
REQ-007 A write SHALL be accepted when wvalid && wready; bytes 0..wbyte-1 are stored at wptr upward, modulo DEPTH_B, and wptr advances by wbyte with wrap at DEPTH_B.
REQ-008 When wvalid && !wready, the write SHALL be dropped, and ovf_err SHALL be set on the next edge.
REQ-009 wbyte > NB SHALL be treated as dropped, and ovf_err SHALL be set; wbyte = 0 SHALL be an accepted no-op.
REQ-010 A read SHALL be accepted when rreq && rbyte <= vbyte, where vbyte is the pre-edge value.
- rdata is registered: next cycle it holds bytes rptr..rptr+rbyte-1, modulo DEPTH_B, in byte positions 0..rbyte-1.
- Bytes rbyte..NB-1 of rdata are zero.
- rvld = 1 for exactly that one cycle.
REQ-011 An accepted read with rpeek = 0 SHALL advance rptr by rbyte, modulo DEPTH_B; with rpeek = 1, rptr and vbyte SHALL be unchanged.
REQ-012 When rreq && rbyte > vbyte, the read SHALL be rejected: rvld = 0 next cycle, rdata holds its previous value, rptr is unchanged, and udf_err SHALL be set.
REQ-013 When rreq = 0, rvld SHALL be 0 on the next cycle, and rdata SHALL hold its value.
REQ-014 Read-latency from rreq to rvld SHALL be 1 cycle, and reads SHALL be back-to-back capable every cycle.
REQ-015 On a simultaneous accepted write and accepted read:
- vbyte SHALL become vbyte + wbyte - (rpeek ? 0 : rbyte).
- The read sees only pre-edge contents; there is no write-to-read bypass.
REQ-016 vbyte SHALL never exceed DEPTH_B or go below 0, which follows from REQ-006 through REQ-012.
REQ-017 init_pulse SHALL have priority over all requests: it clears pointers, vbyte, the buffer, rdata, rvld and both error flags, and it ignores same-cycle writes and reads.
REQ-018 ovf_err and udf_err SHALL stay set until init_pulse or reset.

Reset
REQ-019 Reset SHALL act asynchronously on assertion of reset_n = 0, regardless of clk.
REQ-020 Reset values SHALL be: buffer = 0, wptr = 0, rptr = 0, vbyte = 0, fbyte = DEPTH_B, wready = 1, rdata = 0, rvld = 0, ovf_err = 0, udf_err = 0.
REQ-021 A reset asserted mid-operation SHALL discard any in-flight request, and no rvld pulse SHALL follow deassertion.

Verification
(All scenarios use DW = 64, so NB = 8, and DEPTH_B = 24.)
REQ-022 Fill: write wbyte = 5 (0x01..05), then 8 (0x06..0D), then 8 (0x0E..15).
- vbyte steps 5, 13, 21.
- wready = 0 after the third write (fbyte = 3).
- A fourth write is dropped, and ovf_err = 1.
REQ-023 Partial read: after REQ-022, rreq with rbyte = 3.
- Next cycle: rvld = 1 and rdata = 0x0000000000030201.
- vbyte = 18.
REQ-024 Wrap: from reset, write 8, 8, 8 and read 8, 8, so that rptr = 16 and wptr = 0.
- Then write 8 bytes 0xA0..A7, and read rbyte = 8 twice.
- The second read returns 0xA0..A7, confirming data crosses the DEPTH_B boundary intact.
REQ-025 Peek and underflow: with vbyte = 4:
- rreq with rpeek = 1 and rbyte = 4 gives rvld = 1 with vbyte still 4.
- Then rreq with rbyte = 6 gives rvld = 0, udf_err = 1, and vbyte still 4.
REQ-026 Simultaneous: with vbyte = 10, write wbyte = 8 and read rbyte = 8 in the same cycle.
- vbyte = 10 next cycle.
- rdata equals the oldest 8 pre-edge bytes.
REQ-027 Init and reset: with vbyte = 12 and both error flags set, pulse init_pulse together with wvalid.
- All outputs return to their REQ-020 values, and the write is ignored.
- Repeat with reset_n asserted low between clk edges: the outputs clear immediately.

Source files
------------

// File: rtl/rshp_bfifo.sv
// Byte-granular reshaping FIFO: variable-width writes and reads of 0..NB bytes
// into a circular byte buffer of DEPTH_B entries, with registered read data.
module rshp_bfifo #(
  parameter  int DW      = 512,
  parameter  int DEPTH_B = 192,
  localparam int NB      = DW / 8,
  localparam int BW      = $clog2(NB) + 1,
  localparam int CW      = $clog2(DEPTH_B) + 1,
  localparam int PW      = $clog2(DEPTH_B)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          init_pulse,
  input  logic          wvalid,
  input  logic [BW-1:0] wbyte,
  input  logic [DW-1:0] wdata,
  output logic          wready,
  input  logic          rreq,
  input  logic [BW-1:0] rbyte,
  input  logic          rpeek,
  output logic [DW-1:0] rdata,
  output logic          rvld,
  output logic [CW-1:0] vbyte,
  output logic [CW-1:0] fbyte,
  output logic          ovf_err,
  output logic          udf_err
);
  localparam int NI = $clog2(NB);

  logic [7:0]    mem    [DEPTH_B];
  logic          mem_we [DEPTH_B];
  logic [7:0]    mem_wd [DEPTH_B];
  logic [7:0]    wr_byte [NB];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] vbyte_q, vbyte_n;
  logic [DW-1:0] rd_data_p0, rdata_p1;
  logic          rvld_p1, ovf_q, udf_q;
  logic          wr_ok, wr_bad, rd_ok, rd_bad;

  // Pointer arithmetic: base < DEPTH_B and off <= NB <= DEPTH_B, so one fold suffices.
  function automatic int wrap_add(input int base, input int off);
    int s;
    s = base + off;
    return (s >= DEPTH_B) ? s - DEPTH_B : s;
  endfunction

  assign fbyte   = CW'(DEPTH_B - int'(vbyte_q));
  assign wready  = int'(fbyte) >= NB;
  assign vbyte   = vbyte_q;
  assign rdata   = rdata_p1;
  assign rvld    = rvld_p1;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

  always_comb begin
    wr_ok   = wvalid && wready && (int'(wbyte) <= NB);
    wr_bad  = wvalid && !wr_ok;
    rd_ok   = rreq && (int'(rbyte) <= int'(vbyte_q)) && (int'(rbyte) <= NB);
    rd_bad  = rreq && !rd_ok;
    vbyte_n = CW'(int'(vbyte_q) + (wr_ok ? int'(wbyte) : 0)
                  - ((rd_ok && !rpeek) ? int'(rbyte) : 0));
  end

  always_comb begin
    for (int i = 0; i < NB; i++) wr_byte[i] = wdata[8*i +: 8];
  end

  // Each buffer entry decides from its distance past wptr whether it takes a write lane.
  always_comb begin
    for (int j = 0; j < DEPTH_B; j++) begin
      int off;
      off       = (j >= int'(wptr)) ? j - int'(wptr) : j + DEPTH_B - int'(wptr);
      mem_we[j] = wr_ok && (off < int'(wbyte));
      mem_wd[j] = wr_byte[NI'(off)];
    end
  end

  always_comb begin
    rd_data_p0 = '0;
    for (int i = 0; i < NB; i++)
      if (i < int'(rbyte)) rd_data_p0[8*i +: 8] = mem[PW'(wrap_add(int'(rptr), i))];
  end

  // Stage p0 -> p1: buffer update and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < DEPTH_B; j++) mem[j] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      vbyte_q  <= '0;
      rdata_p1 <= '0;
      rvld_p1  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (init_pulse) begin
      for (int j = 0; j < DEPTH_B; j++) mem[j] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      vbyte_q  <= '0;
      rdata_p1 <= '0;
      rvld_p1  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      for (int j = 0; j < DEPTH_B; j++)
        if (mem_we[j]) mem[j] <= mem_wd[j];
      if (wr_ok) wptr <= PW'(wrap_add(int'(wptr), int'(wbyte)));
      if (rd_ok) begin
        rdata_p1 <= rd_data_p0;
        if (!rpeek) rptr <= PW'(wrap_add(int'(rptr), int'(rbyte)));
      end
      rvld_p1 <= rd_ok;
      vbyte_q <= vbyte_n;
      if (wr_bad) ovf_q <= 1'b1;
      if (rd_bad) udf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rshp_bfifo.sv
// Bench for rshp_bfifo (DW=64, DEPTH_B=24): directed vector table, corner
// sequences, and randomized traffic against a byte-queue reference model.
module tb_rshp_bfifo;
  localparam int DW = 64, DEPTH_B = 24, NB = 8, BW = 4, CW = 6;

  logic          clk = 1'b0;
  logic          reset_n, init_pulse, wvalid, rreq, rpeek;
  logic [BW-1:0] wbyte, rbyte;
  logic [DW-1:0] wdata, rdata;
  logic          wready, rvld, ovf_err, udf_err;
  logic [CW-1:0] vbyte, fbyte;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  mq[$];
  logic [63:0] m_rdata;
  logic        m_rvld, m_ovf, m_udf;

  typedef struct {
    logic          wv;
    logic [BW-1:0] wb;
    logic [63:0]   wd;
    logic          rr;
    logic [BW-1:0] rb;
    logic          rp;
    logic          e_rvld;
    logic [63:0]   e_rdata;
    logic [CW-1:0] e_vbyte;
    logic          e_wready;
    logic          e_ovf;
    logic          e_udf;
  } vec_t;
  vec_t tbl[13];

  rshp_bfifo #(.DW(DW), .DEPTH_B(DEPTH_B)) dut (
    .clk(clk), .reset_n(reset_n), .init_pulse(init_pulse),
    .wvalid(wvalid), .wbyte(wbyte), .wdata(wdata), .wready(wready),
    .rreq(rreq), .rbyte(rbyte), .rpeek(rpeek), .rdata(rdata), .rvld(rvld),
    .vbyte(vbyte), .fbyte(fbyte), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    init_pulse = 1'b0; wvalid = 1'b0; wbyte = '0; wdata = '0;
    rreq = 1'b0; rbyte = '0; rpeek = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata = '0; m_rvld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // FIFO semantics on a byte queue: reads see the pre-edge queue, writes append.
  task automatic model_update();
    int          pre;
    bit          ok;
    logic [63:0] rd;
    if (init_pulse) begin
      model_reset();
      return;
    end
    pre = mq.size();
    ok  = rreq && (int'(rbyte) <= pre);
    rd  = '0;
    if (ok) for (int i = 0; i < int'(rbyte); i++) rd[8*i +: 8] = mq[i];
    if (wvalid) begin
      if ((DEPTH_B - pre) < NB || int'(wbyte) > NB) m_ovf = 1'b1;
      else for (int i = 0; i < int'(wbyte); i++) mq.push_back(wdata[8*i +: 8]);
    end
    if (rreq) begin
      if (ok) begin
        m_rdata = rd;
        if (!rpeek) repeat (int'(rbyte)) void'(mq.pop_front());
      end else m_udf = 1'b1;
    end
    m_rvld = ok;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_rvld"},   64'(rvld),    64'(m_rvld));
    chk({tag, "_rdata"},  rdata,        m_rdata);
    chk({tag, "_vbyte"},  64'(vbyte),   64'(mq.size()));
    chk({tag, "_fbyte"},  64'(fbyte),   64'(DEPTH_B - mq.size()));
    chk({tag, "_wready"}, 64'(wready),  64'((DEPTH_B - mq.size()) >= NB));
    chk({tag, "_ovf"},    64'(ovf_err), 64'(m_ovf));
    chk({tag, "_udf"},    64'(udf_err), 64'(m_udf));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_vbyte"},  64'(vbyte),   64'd0);
    chk({tag, "_fbyte"},  64'(fbyte),   64'd24);
    chk({tag, "_wready"}, 64'(wready),  64'd1);
    chk({tag, "_rdata"},  rdata,        64'd0);
    chk({tag, "_rvld"},   64'(rvld),    64'd0);
    chk({tag, "_ovf"},    64'(ovf_err), 64'd0);
    chk({tag, "_udf"},    64'(udf_err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 4'd5, 64'hEEEEEE0504030201, 1'b0, 4'd0, 1'b0, 1'b0, 64'h0,                 6'd5,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd8, 64'h0D0C0B0A09080706, 1'b0, 4'd0, 1'b0, 1'b0, 64'h0,                 6'd13, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd8, 64'h1514131211100F0E, 1'b0, 4'd0, 1'b0, 1'b0, 64'h0,                 6'd21, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd8, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0, 1'b0, 1'b0, 64'h0,                 6'd21, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 64'h0,                1'b1, 4'd3, 1'b0, 1'b1, 64'h0000000000030201, 6'd18, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 64'h0,                1'b1, 4'd8, 1'b1, 1'b1, 64'h0B0A090807060504, 6'd18, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 64'h0,                1'b1, 4'd8, 1'b0, 1'b1, 64'h0B0A090807060504, 6'd10, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'd8, 64'h2F2E2D2C2B2A2928, 1'b1, 4'd8, 1'b0, 1'b1, 64'h131211100F0E0D0C, 6'd10, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 64'h0,                1'b1, 4'd6, 1'b0, 1'b1, 64'h00002B2A29281514, 6'd4,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 64'h0,                1'b1, 4'd4, 1'b1, 1'b1, 64'h000000002F2E2D2C, 6'd4,  1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'd0, 64'h0,                1'b1, 4'd6, 1'b0, 1'b0, 64'h000000002F2E2D2C, 6'd4,  1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 4'd0, 64'h0,                1'b0, 4'd0, 1'b0, 1'b0, 64'h000000002F2E2D2C, 6'd4,  1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 4'd0, 64'h1234,             1'b0, 4'd0, 1'b0, 1'b0, 64'h000000002F2E2D2C, 6'd4,  1'b1, 1'b1, 1'b1};

    reset_n = 1'b0;
    idle();
    model_reset();
    #2;
    chk_cleared("por");
    @(negedge clk);
    reset_n = 1'b1;
    cycle("idle0");

    for (int k = 0; k < 13; k++) begin
      wvalid = tbl[k].wv; wbyte = tbl[k].wb; wdata = tbl[k].wd;
      rreq = tbl[k].rr; rbyte = tbl[k].rb; rpeek = tbl[k].rp;
      cycle($sformatf("v%0d_model", k));
      chk($sformatf("v%0d_rvld", k),   64'(rvld),    64'(tbl[k].e_rvld));
      chk($sformatf("v%0d_rdata", k),  rdata,        tbl[k].e_rdata);
      chk($sformatf("v%0d_vbyte", k),  64'(vbyte),   64'(tbl[k].e_vbyte));
      chk($sformatf("v%0d_wready", k), 64'(wready),  64'(tbl[k].e_wready));
      chk($sformatf("v%0d_ovf", k),    64'(ovf_err), 64'(tbl[k].e_ovf));
      chk($sformatf("v%0d_udf", k),    64'(udf_err), 64'(tbl[k].e_udf));
    end
    idle();

    // Init pulse with a simultaneous write: vbyte 12, both flags set beforehand
    wvalid = 1'b1; wbyte = 4'd8; wdata = 64'h3736353433323130;
    cycle("fill12");
    chk("fill12_vbyte", 64'(vbyte), 64'd12);
    init_pulse = 1'b1;
    cycle("init");
    chk_cleared("init");
    idle();

    // Oversize write is dropped and flags overflow
    wvalid = 1'b1; wbyte = 4'd9; wdata = 64'hFFFFFFFFFFFFFFFF;
    cycle("wide");
    chk("wide_ovf", 64'(ovf_err), 64'd1);
    chk("wide_vbyte", 64'(vbyte), 64'd0);
    idle(); init_pulse = 1'b1;
    cycle("init2");
    idle();

    // Wrap: rptr=16, wptr=0, then data crossing the buffer end
    for (int k = 0; k < 3; k++) begin
      wvalid = 1'b1; wbyte = 4'd8; wdata = {$urandom, $urandom};
      cycle("wrap_w");
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      rreq = 1'b1; rbyte = 4'd8;
      cycle("wrap_r");
    end
    idle();
    wvalid = 1'b1; wbyte = 4'd8; wdata = 64'hA7A6A5A4A3A2A1A0;
    cycle("wrap_wa");
    idle(); rreq = 1'b1; rbyte = 4'd8;
    cycle("wrap_r3");
    cycle("wrap_r4");
    chk("wrap_rdata", rdata, 64'hA7A6A5A4A3A2A1A0);
    chk("wrap_rvld", 64'(rvld), 64'd1);
    chk("wrap_vbyte", 64'(vbyte), 64'd0);
    idle();

    // Asynchronous reset between edges with requests in flight
    wvalid = 1'b1; wbyte = 4'd8; wdata = 64'h5857565554535251;
    cycle("ar_w");
    idle(); rreq = 1'b1; rbyte = 4'd4;
    cycle("ar_r");
    wvalid = 1'b1; wbyte = 4'd8; rreq = 1'b1; rbyte = 4'd4;
    #2 reset_n = 1'b0;
    #1 chk_cleared("areset");
    model_reset();
    @(posedge clk);
    #1 chk_cleared("areset_hold");
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    cycle("ar_after");
    chk("ar_after_rvld", 64'(rvld), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      init_pulse = ($urandom_range(0, 49) == 0);
      wvalid     = ($urandom_range(0, 2) != 0);
      wbyte      = BW'($urandom_range(0, 9));
      wdata      = {$urandom, $urandom};
      rreq       = ($urandom_range(0, 1) == 1);
      rbyte      = BW'($urandom_range(0, 8));
      rpeek      = ($urandom_range(0, 3) == 0);
      cycle($sformatf("rnd%0d", n));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
